tcam_rule_loader: RTL
=====================

// Module: tcam_rule_loader
// PURPOSE
//  Upstream configuration sequencer for the TCAM wrapper. Accepts one rule per valid/ready handshake
//  (key, byte mask, priority, rule ID) and builds the segment, mask and confirm write words from it.
//  Drives the wrapper's three i_Set_* interfaces with the required enable timing: enables high for HOLD
//  cycles, then one low gap cycle. Replaces hand-sequenced rule writes from software and benches.
// PARAMETERS
//  KWID     104               key width, multiple of 8
//  IDWID    8                 rule ID width
//  PRIOR    8                 priority width
//  HOLD     2                 cycles the set enables stay high per rule; must be >= 1
//  MASKWID  KWID/8            one mask bit per key byte
//  SEGWID   IDWID+2           segment entry: 2-bit status + ID
//  VTWID    SEGWID*MASKWID    segment vector width
//  TOTALWID KWID+MASKWID+PRIOR  confirm string width
// PORTS
//  clk                   in   1         clock, rising edge
//  rst                   in   1         asynchronous reset, active-low
//  i_Rule_Valid          in   1         rule present on i_Rule_*
//  o_Rule_Ready          out  1         loader can accept a rule
//  i_Rule_Key            in   KWID      rule key
//  i_Rule_Mask           in   MASKWID   byte mask; bit MASKWID-1 covers key[KWID-1:KWID-8]
//  i_Rule_Prior          in   PRIOR     rule priority
//  i_Rule_ID             in   IDWID     rule ID
//  i_Clear               in   1         synchronous clear of rule count (and ID table, see CONFIGURATION)
//  o_Set_Key             out  KWID      to wrapper i_Set_Key
//  o_Set_Vector_ID       out  VTWID     to wrapper i_Set_Vector_ID
//  o_Set_Segment_Enable  out  1         to wrapper i_Set_Segment_Enable
//  o_Set_Mask_ID         out  IDWID     to wrapper i_Set_Mask_ID
//  o_Set_Mask_Vector     out  MASKWID   to wrapper i_Set_Mask_Vector
//  o_Set_Mask_Enable     out  1         to wrapper i_Set_Mask_Enable
//  o_Set_Confirm_ID      out  IDWID     to wrapper i_Set_Confirm_ID
//  o_Set_Confirm_String  out  TOTALWID  to wrapper i_Set_Confirm_String
//  o_Set_Confirm_Enable  out  1         to wrapper i_Set_Confirm_Enable
//  o_Done                out  1         one-cycle pulse when a rule write completes
//  o_Error               out  1         one-cycle pulse when a rule is rejected
//  o_Rule_Count          out  IDWID+1   rules written since reset/clear
// BEHAVIOUR
//  - Reset (rst=0): all outputs 0, FSM in IDLE. o_Rule_Ready goes to 1 on the first cycle after release.
//    Reset mid-write drops all enables immediately. The interrupted rule is lost and not counted.
//  - FSM states:
//    - IDLE: o_Rule_Ready=1. On i_Rule_Valid&&o_Rule_Ready at edge T, capture the rule and go to WRITE.
//    - WRITE: lasts HOLD cycles, T+1..T+HOLD. All three enables are 1; o_Rule_Ready=0.
//    - GAP: one cycle, T+HOLD+1. Enables are 0. o_Done=1, o_Rule_Count is incremented at the end of
//      this cycle, then the FSM returns to IDLE.
//    - Throughput: one rule per HOLD+2 cycles.
//  - Write words are registered at capture and held stable through WRITE and GAP:
//    - Key = i_Rule_Key.
//    - Vector_ID = {MASKWID{2'b01, ID}}.
//    - Mask_Vector = i_Rule_Mask.
//    - Mask_ID = Confirm_ID = ID.
//    - Confirm_String = {Prior, Mask, Key}.
//    After GAP, the data outputs keep their last values; only the enables return to 0.
//  - Input changes or i_Rule_Valid toggling during WRITE/GAP are ignored.
//  - o_Rule_Count saturates at 2**IDWID.
//  - i_Clear is honoured in any state and does not abort a write in flight. If i_Clear and the GAP-cycle
//    increment coincide, clear wins (count=0).
// CONFIGURATION
//  TCAM_LOADER_DUP_CHECK_EN defined:
//   - A 2**IDWID-bit written-ID table is added, cleared by reset and i_Clear.
//   - At handshake, if table[i_Rule_ID]=1, the rule is consumed but rejected: o_Error pulses at T+1,
//     no enables are raised, the count is unchanged, and the FSM stays in IDLE.
//   - Otherwise the table bit is set when GAP ends.
//  TCAM_LOADER_DUP_CHECK_EN undefined:
//   - No table is built; o_Error is tied to 0.
//   - Duplicate IDs are rewritten and counted.
// TESTING
//  1 Reset: hold rst=0 for 2 cycles -> all outputs 0; o_Rule_Ready=1 on the first cycle after release.
//  2 Single rule: key=104'h405B6A00A4680000FFFFFFFFFF, mask=13'b0001001100000, prior=8'h00, ID=8'h00
//    -> enables high for exactly 2 cycles; Vector_ID={13{2'b01,8'h00}};
//    Confirm_String={8'h00, mask, key}; o_Done pulses; count=1.
//  3 Ten rules, IDs 0x00..0x09, valid held continuously -> 10 handshakes 4 cycles apart;
//    enable pattern 1,1,0 after each accept; count=10.
//  4 During WRITE, change i_Rule_Key to all ones and toggle i_Rule_Valid
//    -> o_Set_* values and the enable pattern are unchanged.
//  5 Write ID 0x03 twice -> with the macro: second o_Error=1, no enables, count=1;
//    without the macro: second write performed, count=2.
//  6 Assert rst mid-WRITE, then assert i_Clear during a GAP -> enables drop immediately on reset;
//    count=0 after the clear.

Source files
------------

// File: rtl/tcam_rule_loader.sv
// Rule loader for the TCAM wrapper: takes one rule per valid/ready handshake and drives the
// segment/mask/confirm write interfaces. Define TCAM_LOADER_DUP_CHECK_EN to reject duplicate IDs.
module tcam_rule_loader #(
    parameter int KWID  = 104,
    parameter int IDWID = 8,
    parameter int PRIOR = 8,
    parameter int HOLD  = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 i_Rule_Valid,
    output logic                                 o_Rule_Ready,
    input  logic [KWID-1:0]                      i_Rule_Key,
    input  logic [KWID/8-1:0]                    i_Rule_Mask,
    input  logic [PRIOR-1:0]                     i_Rule_Prior,
    input  logic [IDWID-1:0]                     i_Rule_ID,
    input  logic                                 i_Clear,
    output logic [KWID-1:0]                      o_Set_Key,
    output logic [(IDWID+2)*(KWID/8)-1:0]        o_Set_Vector_ID,
    output logic                                 o_Set_Segment_Enable,
    output logic [IDWID-1:0]                     o_Set_Mask_ID,
    output logic [KWID/8-1:0]                    o_Set_Mask_Vector,
    output logic                                 o_Set_Mask_Enable,
    output logic [IDWID-1:0]                     o_Set_Confirm_ID,
    output logic [KWID+KWID/8+PRIOR-1:0]         o_Set_Confirm_String,
    output logic                                 o_Set_Confirm_Enable,
    output logic                                 o_Done,
    output logic                                 o_Error,
    output logic [IDWID:0]                       o_Rule_Count
);

    localparam int MASKWID  = KWID / 8;
    localparam int SEGWID   = IDWID + 2;
    localparam int VTWID    = SEGWID * MASKWID;
    localparam int TOTALWID = KWID + MASKWID + PRIOR;
    localparam int CWID     = (HOLD > 1) ? $clog2(HOLD) : 1;

    localparam logic [CWID-1:0]  HOLD_LAST = CWID'(HOLD - 1);
    localparam logic [IDWID:0]   COUNT_MAX = {1'b1, {IDWID{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_GAP
    } state_t;

    state_t            state, state_next;
    logic [CWID-1:0]   hold_cnt, hold_next;
    logic              ready;
    logic              accept;
    logic              dup;
    logic              capture;

    logic [KWID-1:0]     key_q;
    logic [VTWID-1:0]    vector_q;
    logic [MASKWID-1:0]  mask_q;
    logic [IDWID-1:0]    id_q;
    logic [TOTALWID-1:0] confirm_q;
    logic [IDWID:0]      count;

    assign accept = i_Rule_Valid && ready;

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            hold_cnt <= '0;
            ready    <= 1'b0;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_next;
            ready    <= (state_next == S_IDLE);
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        hold_next  = hold_cnt;
        capture    = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept && !dup) begin
                    capture    = 1'b1;
                    hold_next  = '0;
                    state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_next = S_GAP;
                end else begin
                    hold_next = hold_cnt + CWID'(1);
                end
            end
            S_GAP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Write words are captured once and held until the next accepted rule.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_q     <= '0;
            vector_q  <= '0;
            mask_q    <= '0;
            id_q      <= '0;
            confirm_q <= '0;
        end else if (capture) begin
            key_q     <= i_Rule_Key;
            vector_q  <= {MASKWID{2'b01, i_Rule_ID}};
            mask_q    <= i_Rule_Mask;
            id_q      <= i_Rule_ID;
            confirm_q <= {i_Rule_Prior, i_Rule_Mask, i_Rule_Key};
        end
    end

    // Clear has priority over the GAP-cycle increment; the count sticks at 2**IDWID.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (i_Clear) begin
            count <= '0;
        end else if (state == S_GAP && count != COUNT_MAX) begin
            count <= count + 1'b1;
        end
    end

`ifdef TCAM_LOADER_DUP_CHECK_EN
    logic [2**IDWID-1:0] id_table;
    logic                error_q;

    assign dup = id_table[i_Rule_ID];

    // NOTE: this table is a flop array, not a RAM, so it can and must be reset along with the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_table <= '0;
            error_q  <= 1'b0;
        end else begin
            error_q <= accept && dup && (state == S_IDLE);
            if (i_Clear) begin
                id_table <= '0;
            end else if (state == S_GAP) begin
                id_table[id_q] <= 1'b1;
            end
        end
    end

    assign o_Error = error_q;
`else
    assign dup     = 1'b0;
    assign o_Error = 1'b0;
`endif

    assign o_Rule_Ready         = ready;
    assign o_Set_Key            = key_q;
    assign o_Set_Vector_ID      = vector_q;
    assign o_Set_Mask_ID        = id_q;
    assign o_Set_Mask_Vector    = mask_q;
    assign o_Set_Confirm_ID     = id_q;
    assign o_Set_Confirm_String = confirm_q;
    assign o_Set_Segment_Enable = (state == S_WRITE);
    assign o_Set_Mask_Enable    = (state == S_WRITE);
    assign o_Set_Confirm_Enable = (state == S_WRITE);
    assign o_Done               = (state == S_GAP);
    assign o_Rule_Count         = count;

endmodule
